// File: rtl/pes_bc_pkg.sv
// Shared constants and next-count arithmetic for the pes_bc counter family.
// Pure combinational helper; no state, no backpressure.
package pes_bc_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Operands are 33 bits so a modulus of 2^32 is representable; returns {ovf, count}.
  function automatic logic [33:0] next_count(
    input logic [32:0] count,
    input logic [32:0] step,
    input logic        dir,
    input logic [32:0] modulo,
    input logic        sat
  );
    logic [33:0] sum;
    logic [32:0] s;
    logic [32:0] res;
    logic        of;
    sum = '0;
    of  = 1'b0;
    res = count;
    s   = (step >= modulo) ? modulo - 33'd1 : step;
    if (s == 33'd0) begin
      res = count;
    end else if (dir == DIR_UP) begin
      sum = {1'b0, count} + {1'b0, s};
      if (sum > {1'b0, modulo} - 34'd1) begin
        of  = 1'b1;
        res = (sat == MODE_SAT) ? modulo - 33'd1 : 33'(sum - {1'b0, modulo});
      end else begin
        res = sum[32:0];
      end
    end else begin
      if (s > count) begin
        of  = 1'b1;
        res = (sat == MODE_SAT) ? 33'd0 : count + modulo - s;
      end else begin
        res = count - s;
      end
    end
    return {of, res};
  endfunction

endpackage

// File: rtl/pes_bc_param.sv
// Parametrised bidirectional mod-N counter with load, wrap/saturate, tc and ovf; PES_BC_STEP_EN adds a step input.
// Latency: Count/ovf update one cycle after the enabling edge; tc is combinational (zero latency).
// Backpressure: none; en gates counting and tc is meant to drive the next stage's en.
module pes_bc_param #(
  parameter int     WIDTH    = 4,
  parameter longint MODULO   = 16,
  parameter bit     SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             UpOrDown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef PES_BC_STEP_EN
  input  logic [WIDTH-1:0] step,
`endif
  output logic [WIDTH-1:0] Count,
  output logic             tc,
  output logic             ovf
);
  import pes_bc_pkg::*;

  localparam logic [32:0]      MOD  = 33'(MODULO);
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MODULO - 1);
  localparam logic             MODE = SATURATE ? MODE_SAT : MODE_WRAP;

  logic [32:0]      step_x;
  logic [33:0]      nc;
  logic [32-WIDTH:0] nc_hi_unused;
  logic [WIDTH-1:0] ld_cnt;

`ifdef PES_BC_STEP_EN
  assign step_x = 33'(step);
`else
  assign step_x = 33'd1;
`endif

  assign nc           = next_count(33'(Count), step_x, UpOrDown, MOD, MODE);
  assign nc_hi_unused = nc[32:WIDTH];
  assign tc           = en & nc[33];
  assign ld_cnt       = (33'(load_val) >= MOD) ? MAXC : load_val;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Count <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      Count <= ld_cnt;
      ovf   <= 1'b0;
    end else if (en) begin
      Count <= nc[WIDTH-1:0];
      ovf   <= nc[33];
    end else begin
      ovf   <= 1'b0;
    end
  end

endmodule
